// File: rtl/uart_tx_scheduler_if.sv
// Producer-side handshake bundle for uart_tx_scheduler: one valid/ready/data/last lane per requester.
interface uart_tx_scheduler_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;

    modport master (output req_valid, output req_data, output req_last, input req_ready);
    modport slave  (input req_valid, input req_data, input req_last, output req_ready);
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one 8N1 UART line between NUM_REQ byte producers, paced by tx_tick.
// Define UART_TX_PKT_LOCK_EN to hold the grant on one requester until it delivers a req_last byte.
module uart_tx_scheduler #(
    parameter int  NUM_REQ  = 2,
    parameter int  GAP_BITS = 0,
    localparam int GW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk_50m,
    input  logic               rst_n,
    input  logic               tx_tick,
    uart_tx_scheduler_if.slave bus,
    output logic               tx,
    output logic               busy,
    output logic [GW-1:0]      grant_id
);
    localparam int IW = GW + 1;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, STOP} state_t;

    state_t             state;
    state_t             state_next;
    logic [7:0]         shift_reg;
    logic [2:0]         bit_cnt;
    logic [3:0]         gap_cnt;
    logic               stop_sent;
    logic [GW-1:0]      last_grant;
    logic [GW-1:0]      winner;
    logic [IW-1:0]      idx;
    logic               found;
    logic               accept;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] ready_vec;

`ifdef UART_TX_PKT_LOCK_EN
    logic          lock_active;
    logic [GW-1:0] lock_id;

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            lock_active <= 1'b0;
            lock_id     <= '0;
        end else if (accept) begin
            lock_active <= ~bus.req_last[winner];
            lock_id     <= winner;
        end
    end

    always_comb begin
        eligible = bus.req_valid;
        if (lock_active) eligible = bus.req_valid & (NUM_REQ'(1) << lock_id);
    end
`else
    logic unused_last;
    assign unused_last = ^bus.req_last;
    assign eligible    = bus.req_valid;
`endif

    // Search starts just after the previous winner; sum stays below 2*NUM_REQ so one subtract wraps it.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = {1'b0, last_grant} + IW'(k);
            if (idx >= IW'(NUM_REQ)) idx = idx - IW'(NUM_REQ);
            if (!found && eligible[idx[GW-1:0]]) begin
                found  = 1'b1;
                winner = idx[GW-1:0];
            end
        end
    end

    assign accept = (state == IDLE) && found && rst_n;

    always_comb begin
        ready_vec = '0;
        if (accept) ready_vec[winner] = 1'b1;
    end

    assign bus.req_ready = ready_vec;
    assign busy          = (state != IDLE);

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = LOAD;
            LOAD:    if (tx_tick) state_next = SHIFT;
            SHIFT:   if (tx_tick && bit_cnt == 3'd7) state_next = STOP;
            STOP:    if (tx_tick && stop_sent && gap_cnt == 4'd0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A tick landing on the accept cycle is dropped: IDLE never looks at tx_tick.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            tx         <= 1'b1;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            stop_sent  <= 1'b0;
            last_grant <= GW'(NUM_REQ - 1);
            grant_id   <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    shift_reg  <= bus.req_data[{winner, 3'b000} +: 8];
                    last_grant <= winner;
                    grant_id   <= winner;
                end
                LOAD: if (tx_tick) begin
                    tx        <= 1'b0;
                    bit_cnt   <= '0;
                    stop_sent <= 1'b0;
                end
                SHIFT: if (tx_tick) begin
                    tx        <= shift_reg[0];
                    shift_reg <= {1'b0, shift_reg[7:1]};
                    bit_cnt   <= bit_cnt + 3'd1;
                end
                STOP: if (tx_tick) begin
                    if (!stop_sent) begin
                        tx        <= 1'b1;
                        gap_cnt   <= 4'(GAP_BITS);
                        stop_sent <= 1'b1;
                    end else if (gap_cnt != 4'd0) begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler: dut0 (2 requesters, no gap) and dut2 (1 requester, GAP_BITS=2).
// Expected frames are queued with the stimulus; a line monitor decodes tx and pops them.
module tb_uart_tx_scheduler;
    localparam int TICK_DIV = 4;

    logic clk_50m = 1'b0;
    logic rst_n   = 1'b1;
    logic rst2_n  = 1'b1;
    logic gap_en  = 1'b0;
    logic tx_tick;
    logic tick_q  = 1'b0;
    int   cyc     = 0;
    int   tick_no = 0;
    int   busy_ticks = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic       tx0, busy0, tx2, busy2;
    logic [0:0] gid0, gid2;

    always #10 clk_50m = ~clk_50m;

    assign tx_tick = (cyc % TICK_DIV) == (TICK_DIV - 1);

    always @(posedge clk_50m) begin
        cyc    <= cyc + 1;
        tick_q <= tx_tick;
        if (tx_tick) tick_no <= tick_no + 1;
        if (tx_tick && busy0) busy_ticks <= busy_ticks + 1;
    end

    uart_tx_scheduler_if #(.NUM_REQ(2)) bus0 ();
    uart_tx_scheduler_if #(.NUM_REQ(1)) bus2 ();

    uart_tx_scheduler #(.NUM_REQ(2), .GAP_BITS(0)) dut0 (
        .clk_50m(clk_50m), .rst_n(rst_n), .tx_tick(tx_tick), .bus(bus0),
        .tx(tx0), .busy(busy0), .grant_id(gid0)
    );

    uart_tx_scheduler #(.NUM_REQ(1), .GAP_BITS(2)) dut2 (
        .clk_50m(clk_50m), .rst_n(rst2_n), .tx_tick(tx_tick), .bus(bus2),
        .tx(tx2), .busy(busy2), .grant_id(gid2)
    );

    assign bus2.req_valid = gap_en;
    assign bus2.req_data  = 8'h5A;
    assign bus2.req_last  = 1'b1;

    // Each requester of dut0 is a small FIFO of {last, data}; it pops on valid & ready.
    logic [8:0]  src_mem [2][32];
    int          src_head [2] = '{0, 0};
    int          src_tail [2] = '{0, 0};
    logic [1:0]  v0, l0;
    logic [15:0] d0;

    always_comb begin
        v0 = '0;
        l0 = '0;
        d0 = '0;
        for (int r = 0; r < 2; r++) begin
            v0[r]        = (src_head[r] != src_tail[r]);
            d0[8*r +: 8] = src_mem[r][src_head[r]][7:0];
            l0[r]        = src_mem[r][src_head[r]][8];
        end
    end

    assign bus0.req_valid = v0;
    assign bus0.req_data  = d0;
    assign bus0.req_last  = l0;

    always @(posedge clk_50m)
        for (int r = 0; r < 2; r++)
            if (bus0.req_valid[r] && bus0.req_ready[r]) src_head[r] <= (src_head[r] + 1) % 32;

    typedef struct {
        int gid;
        int data;
        int pitch;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("[TB] FAIL %s: bound expired, expected event", name);
    endtask

    task automatic apply_stimulus(input int r, input logic [7:0] data, input logic last);
        src_mem[r][src_tail[r]] = {last, data};
        src_tail[r] = (src_tail[r] + 1) % 32;
    endtask

    task automatic expect_frame(input int gid, input int data, input int pitch);
        exp_t e;
        e.gid   = gid;
        e.data  = data;
        e.pitch = pitch;
        exp_q.push_back(e);
    endtask

    // Line monitor for dut0: start bit, 8 data bits LSB first, stop bit, then scoreboard pop.
    int         mon_cnt = 0;
    int         mon_gid = 0;
    int         mon_pitch = 0;
    int         last_start = -1;
    logic [7:0] mon_byte = '0;

    always @(negedge clk_50m) begin
        if (!rst_n) begin
            mon_cnt    = 0;
            last_start = -1;
        end else if (tick_q) begin
            if (mon_cnt == 0) begin
                if (tx0 == 1'b0) begin
                    mon_pitch  = (last_start < 0) ? 0 : tick_no - last_start;
                    last_start = tick_no;
                    mon_gid    = int'(gid0);
                    mon_cnt    = 1;
                end
            end else if (mon_cnt <= 8) begin
                mon_byte[mon_cnt-1] = tx0;
                mon_cnt++;
            end else begin
                check_output("stop bit", tx0, 1);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL unexpected frame: got data %02h, expected none", mon_byte);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_output("frame data", mon_byte, mon_e.data);
                    check_output("frame grant", mon_gid, mon_e.gid);
                    if (mon_e.pitch > 0) check_output("frame pitch", mon_pitch, mon_e.pitch);
                end
                mon_cnt = 0;
            end
        end
    end

    // Line monitor for dut2: fixed byte 0x5A, start-to-start spacing of 13 ticks.
    int         m2_cnt = 0;
    int         m2_last = -1;
    int         m2_frames = 0;
    logic [7:0] m2_byte = '0;

    always @(negedge clk_50m) begin
        if (!rst2_n) begin
            m2_cnt  = 0;
            m2_last = -1;
        end else if (tick_q) begin
            if (m2_cnt == 0) begin
                if (tx2 == 1'b0) begin
                    if (m2_last >= 0) check_output("gap pitch", tick_no - m2_last, 13);
                    m2_last = tick_no;
                    check_output("gap grant", gid2, 0);
                    m2_cnt = 1;
                end
            end else if (m2_cnt <= 8) begin
                m2_byte[m2_cnt-1] = tx2;
                m2_cnt++;
            end else begin
                check_output("gap stop bit", tx2, 1);
                check_output("gap data", m2_byte, 8'h5A);
                m2_frames++;
                m2_cnt = 0;
            end
        end
    end

    task automatic wait_tick();
        int n = 0;
        do begin
            @(negedge clk_50m);
            n++;
        end while (!tick_q && n < 4 * TICK_DIV);
        if (!tick_q) fail_now("tick wait");
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        do begin
            @(negedge clk_50m);
            n++;
        end while ((exp_q.size() != 0 || busy0) && n < 3000);
        check_output({name, " pending frames"}, exp_q.size(), 0);
        check_output({name, " busy after drain"}, busy0, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int r = 0; r < 2; r++) src_tail[r] = src_head[r];
        exp_q.delete();
        repeat (3) @(negedge clk_50m);
        check_output("reset tx", tx0, 1);
        check_output("reset busy", busy0, 0);
        check_output("reset grant_id", gid0, 0);
        rst_n = 1'b1;
        @(negedge clk_50m);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int sb_bits [9] = '{1, 0, 1, 0, 0, 1, 0, 1, 1};
        int n;
        int bt0;

        rst2_n = 1'b0;
        do_reset();

        $display("[TB] single byte 0xA5 from req0");
        bt0 = busy_ticks;
        expect_frame(0, 8'hA5, 0);
        apply_stimulus(0, 8'hA5, 1'b1);
        n = 0;
        do begin
            @(negedge clk_50m);
            n++;
        end while (!(tick_q && tx0 == 1'b0) && n < 200);
        check_output("sb start bit", tx0, 0);
        for (int i = 0; i < 9; i++) begin
            wait_tick();
            check_output("sb tx bit", tx0, sb_bits[i]);
        end
        check_output("sb grant_id", gid0, 0);
        wait_drain("sb");
        check_output("sb busy ticks", busy_ticks - bt0, 11);

        $display("[TB] round-robin with both requesters valid");
        do_reset();
        expect_frame(0, 8'h01, 0);
        expect_frame(1, 8'h81, 11);
        expect_frame(0, 8'h02, 11);
        expect_frame(1, 8'h82, 11);
        apply_stimulus(0, 8'h01, 1'b1);
        apply_stimulus(0, 8'h02, 1'b1);
        apply_stimulus(1, 8'h81, 1'b1);
        apply_stimulus(1, 8'h82, 1'b1);
        wait_drain("rr");

        $display("[TB] packet of three bytes from req0 against req1");
        do_reset();
`ifdef UART_TX_PKT_LOCK_EN
        expect_frame(0, 8'h11, 0);
        expect_frame(0, 8'h22, 11);
        expect_frame(0, 8'h33, 11);
        expect_frame(1, 8'hC1, 11);
        expect_frame(1, 8'hC2, 11);
`else
        expect_frame(0, 8'h11, 0);
        expect_frame(1, 8'hC1, 11);
        expect_frame(0, 8'h22, 11);
        expect_frame(1, 8'hC2, 11);
        expect_frame(0, 8'h33, 11);
`endif
        apply_stimulus(0, 8'h11, 1'b0);
        apply_stimulus(0, 8'h22, 1'b0);
        apply_stimulus(0, 8'h33, 1'b1);
        apply_stimulus(1, 8'hC1, 1'b1);
        apply_stimulus(1, 8'hC2, 1'b1);
        wait_drain("lock");

        $display("[TB] tick coinciding with accept");
        do_reset();
        n = 0;
        while (!tx_tick && n < 4 * TICK_DIV) begin
            @(negedge clk_50m);
            n++;
        end
        if (!tx_tick) fail_now("align to tick");
        expect_frame(0, 8'h3C, 0);
        apply_stimulus(0, 8'h3C, 1'b1);
        @(negedge clk_50m);
        check_output("toa tx after accept tick", tx0, 1);
        check_output("toa busy after accept", busy0, 1);
        wait_tick();
        check_output("toa start on next tick", tx0, 0);
        wait_drain("toa");

        $display("[TB] reset during data bit 3");
        do_reset();
        expect_frame(0, 8'hF0, 0);
        apply_stimulus(0, 8'hF0, 1'b1);
        n = 0;
        while (mon_cnt != 5 && n < 400) begin
            @(negedge clk_50m);
            n++;
        end
        check_output("rst reached bit3", mon_cnt, 5);
        check_output("rst line low before reset", tx0, 0);
        rst_n = 1'b0;
        #1;
        check_output("rst tx immediate", tx0, 1);
        check_output("rst busy immediate", busy0, 0);
        exp_q.delete();
        apply_stimulus(1, 8'h77, 1'b1);
        apply_stimulus(0, 8'h66, 1'b1);
        #1;
        check_output("rst ready held low", bus0.req_ready, 0);
        repeat (2) @(negedge clk_50m);
        expect_frame(0, 8'h66, 0);
        expect_frame(1, 8'h77, 11);
        rst_n = 1'b1;
        wait_drain("rst");

        $display("[TB] GAP_BITS=2 streaming on single requester");
        gap_en = 1'b1;
        @(negedge clk_50m);
        check_output("gap ready in reset", bus2.req_ready, 0);
        check_output("gap busy in reset", busy2, 0);
        rst2_n = 1'b1;
        n = 0;
        while (m2_frames < 4 && n < 2000) begin
            @(negedge clk_50m);
            n++;
        end
        check_output("gap frames seen", m2_frames, 4);
        gap_en = 1'b0;
        rst2_n = 1'b0;
        repeat (2) @(negedge clk_50m);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
